// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   - Bit positions of the forwarding fields merged into idCtrl/exCtrl/memCtrl.
//   - Controller FSM state encoding.
//   - Shadow entry tracking dest-reg/write/load info for one pipeline stage.
//   - regMatch helper: true when a stage writes a nonzero source register.
package pipeline_ctrl_pkg;

  localparam int REG_BITS = 5;

  // Positions of the forwarding selects inside the decoder control words
  localparam int ID_CTRL_FWD_A_BIT     = 0;  // exMemIdA
  localparam int ID_CTRL_FWD_B_BIT     = 1;  // exMemIdB
  localparam int EX_CTRL_FWD_MEM_A_BIT = 0;  // exMemExA
  localparam int EX_CTRL_FWD_MEM_B_BIT = 1;  // exMemExB
  localparam int EX_CTRL_FWD_WB_A_BIT  = 2;  // memWbExA
  localparam int EX_CTRL_FWD_WB_B_BIT  = 3;  // memWbExB
  localparam int MEM_CTRL_FWD_WB_BIT   = 0;  // memWbMem

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrlState_t;

  typedef struct packed {
    logic [REG_BITS-1:0] rw;
    logic                regWr;
    logic                load;
  } shadowEntry_t;

  // Register 0 is hardwired, so it never produces a match.
  function automatic logic regMatch(input logic [REG_BITS-1:0] src,
                                    input shadowEntry_t entry);
    return entry.regWr && (entry.rw == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow entry (dest reg, reg write, load) for a single pipeline stage.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   clear                 synchronous clear (bubble enters this stage)
//   rwIn/regWrIn/loadIn   entry captured on the next rising edge
//   rwOut/regWrOut/loadOut current entry
module hazard_shadow_stage
  import pipeline_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [REG_BITS-1:0] rwIn,
  input  logic                regWrIn,
  input  logic                loadIn,
  output logic [REG_BITS-1:0] rwOut,
  output logic                regWrOut,
  output logic                loadOut
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rwOut    <= '0;
      regWrOut <= 1'b0;
      loadOut  <= 1'b0;
    end else begin
      rwOut    <= rwIn;
      regWrOut <= regWrIn;
      loadOut  <= loadIn;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline.
// Watches the instruction in ID, shadows dest-reg info for EX/MEM/WB and
// drives forwarding selects, load-use/branch stalls, bubbles and drain.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_rs1/id_rs2               source registers of the ID instruction
//   id_use_rs1/id_use_rs2       operands read in EX
//   id_branch                   rs1 compared in ID
//   id_store                    rs2 is store data consumed in MEM
//   id_rw/id_reg_wr/id_load     destination info of the ID instruction
//   id_halt                     ID instruction is halt
//   fwd_id_a/fwd_id_b           ID-stage forward from EX/MEM ALU result
//   fwd_ex_mem_a/b, fwd_ex_wb_a/b  EX-stage operand forwards
//   fwd_mem_wb                  store data from WB write bus
//   stall/ifid_wr/id_bubble     front-end hold and bubble insertion
//   end_program                 one-cycle pulse once the pipeline drained
//
// state  | meaning
// RUN    | normal issue, hazards evaluated every cycle
// DRAIN  | halt passed into EX, counting until the pipeline is empty
// HALTED | program finished, front end frozen until reset
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_branch,
  input  logic                id_store,
  input  logic [REG_BITS-1:0] id_rw,
  input  logic                id_reg_wr,
  input  logic                id_load,
  input  logic                id_halt,
  output logic                fwd_id_a,
  output logic                fwd_id_b,
  output logic                fwd_ex_mem_a,
  output logic                fwd_ex_mem_b,
  output logic                fwd_ex_wb_a,
  output logic                fwd_ex_wb_b,
  output logic                fwd_mem_wb,
  output logic                stall,
  output logic                ifid_wr,
  output logic                id_bubble,
  output logic                end_program
);

  localparam int CNT_BITS = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] DRAIN_LAST = CNT_BITS'(DRAIN_CYCLES);

  ctrlState_t state, stateNext;
  logic [CNT_BITS-1:0] drainCnt, drainCntNext;

  shadowEntry_t exEntry, memEntry, wbEntry;

  hazard_shadow_stage exStage (
    .clk      (clk),
    .reset    (reset),
    .clear    (id_bubble),
    .rwIn     (id_rw),
    .regWrIn  (id_reg_wr),
    .loadIn   (id_load),
    .rwOut    (exEntry.rw),
    .regWrOut (exEntry.regWr),
    .loadOut  (exEntry.load)
  );

  hazard_shadow_stage memStage (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .rwIn     (exEntry.rw),
    .regWrIn  (exEntry.regWr),
    .loadIn   (exEntry.load),
    .rwOut    (memEntry.rw),
    .regWrOut (memEntry.regWr),
    .loadOut  (memEntry.load)
  );

  hazard_shadow_stage wbStage (
    .clk      (clk),
    .reset    (reset),
    .clear    (1'b0),
    .rwIn     (memEntry.rw),
    .regWrIn  (memEntry.regWr),
    .loadIn   (memEntry.load),
    .rwOut    (wbEntry.rw),
    .regWrOut (wbEntry.regWr),
    .loadOut  (wbEntry.load)
  );

  // The regfile writes on the falling edge, so WB never needs a forward;
  // the WB entry is kept only so the shadow mirrors the real pipeline.
  logic unusedWbBits;
  assign unusedWbBits = ^wbEntry;

  logic rs1MatchEx, rs2MatchEx, rs1MatchMem, rs2MatchMem;
  logic storeData, exMemA, exMemB, exWbA, exWbB, idFwdA, idFwdB;
  logic loadUse, branchStall, hazard;

  assign rs1MatchEx  = regMatch(id_rs1, exEntry);
  assign rs2MatchEx  = regMatch(id_rs2, exEntry);
  assign rs1MatchMem = regMatch(id_rs1, memEntry);
  assign rs2MatchMem = regMatch(id_rs2, memEntry);

  // Load directly ahead of a store of the same register: the data is
  // picked up from busW in MEM, so no stall and no EX-stage b forward.
  assign storeData = id_store & rs2MatchEx & exEntry.load;

  assign exMemA = id_use_rs1 & rs1MatchEx & ~exEntry.load;
  assign exMemB = id_use_rs2 & rs2MatchEx & ~exEntry.load;
  assign exWbA  = id_use_rs1 & rs1MatchMem & ~exMemA;
  assign exWbB  = id_use_rs2 & rs2MatchMem & ~exMemB & ~storeData;
  assign idFwdA = id_branch & rs1MatchMem & ~memEntry.load;
  assign idFwdB = id_branch & rs2MatchMem & ~memEntry.load;

  assign loadUse     = exEntry.load & ((id_use_rs1 & rs1MatchEx) |
                                       (id_use_rs2 & rs2MatchEx & ~storeData));
  assign branchStall = id_branch & (rs1MatchEx | (rs1MatchMem & memEntry.load));
  assign hazard      = loadUse | branchStall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      drainCnt <= '0;
    end else begin
      state    <= stateNext;
      drainCnt <= drainCntNext;
    end
  end

  always_comb begin
    stateNext    = state;
    drainCntNext = drainCnt;
    fwd_id_a     = 1'b0;
    fwd_id_b     = 1'b0;
    fwd_ex_mem_a = 1'b0;
    fwd_ex_mem_b = 1'b0;
    fwd_ex_wb_a  = 1'b0;
    fwd_ex_wb_b  = 1'b0;
    fwd_mem_wb   = 1'b0;
    stall        = 1'b0;
    ifid_wr      = 1'b0;
    id_bubble    = 1'b1;
    end_program  = 1'b0;
    case (state)
      RUN: begin
        if (hazard) begin
          stall = 1'b1;
        end else begin
          ifid_wr      = 1'b1;
          id_bubble    = 1'b0;
          fwd_id_a     = idFwdA;
          fwd_id_b     = idFwdB;
          fwd_ex_mem_a = exMemA;
          fwd_ex_mem_b = exMemB;
          fwd_ex_wb_a  = exWbA;
          fwd_ex_wb_b  = exWbB;
          fwd_mem_wb   = storeData;
          if (id_halt) begin
            stateNext    = DRAIN;
            drainCntNext = CNT_BITS'(1);
          end
        end
      end
      DRAIN: begin
        if (drainCnt == DRAIN_LAST) begin
          end_program  = 1'b1;
          stateNext    = HALTED;
          drainCntNext = '0;
        end else begin
          drainCntNext = drainCnt + 1'b1;
        end
      end
      HALTED: begin
      end
      default: begin
        stateNext    = RUN;
        drainCntNext = '0;
      end
    endcase
  end

endmodule
